eeg_oram_bank: RTL

- Next-generation output RAM for the EEG datapath.
- Holds CH independent single-port-pair (1R1W) channel memories of DEPTH words × DW bits.
- Adds three things: a per-write accumulate mode (read-modify-write, signed saturating); a read path that tolerates consumer backpressure through a per-channel output FIFO; a global zero-fill clear engine.
- Sits between the PE array's result writers and the output/DMA readers.

---
 rtl/eeg_oram_pkg.sv | 26 ++
 rtl/eeg_oram_chn.sv | 132 +++++++++++++
 rtl/eeg_oram_bank.sv | 89 ++++++++
 3 files changed

// File: rtl/eeg_oram_pkg.sv
// Shared definitions for the EEG output RAM bank: default sizes, clear-FSM
// state encodings and the signed saturating adder used by accumulate writes.
package eeg_oram_pkg;

  localparam int CH_DEF          = 16;
  localparam int DEPTH_DEF       = 256;
  localparam int DW_DEF          = 8;
  localparam int OFIFO_DEPTH_DEF = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CLR  = 1'b1;

  // Clamp a + b into the signed range of a dw-bit word.
  function automatic int sat_add(input int a, input int b, input int dw);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (dw - 1)) - 1;
    lo  = -(1 << (dw - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/eeg_oram_chn.sv
// One output-RAM channel: 1R1W memory, two-stage accumulate with read
// forwarding, and a credit-controlled output FIFO for the read path.
module eeg_oram_chn import eeg_oram_pkg::*; #(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int DW          = DW_DEF,
  parameter int OFIFO_DEPTH = OFIFO_DEPTH_DEF,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          open_i,
  input  logic          clr_we_i,
  input  logic [AW-1:0] clr_add_i,
  input  logic          din_vld_i,
  output logic          din_rdy_o,
  input  logic          din_acc_i,
  input  logic [AW-1:0] din_add_i,
  input  logic [DW-1:0] din_dat_i,
  input  logic          add_vld_i,
  input  logic          add_lst_i,
  output logic          add_rdy_o,
  input  logic [AW-1:0] add_add_i,
  output logic          dat_vld_o,
  output logic          dat_lst_o,
  input  logic          dat_rdy_i,
  output logic [DW-1:0] dat_dat_o
);
  localparam int OW = $clog2(OFIFO_DEPTH + 1);
  localparam int PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int CW = OW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(OFIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(OFIFO_DEPTH - 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(OFIFO_DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_dout_q;
  logic          ram_we;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [DW-1:0] ram_wd;

  logic          acc_p_q, infl_q, lst_q, fwd_q;
  logic [AW-1:0] din_add_q;
  logic [DW-1:0] din_dat_q, fwd_dat_q, acc_dat, push_dat;
  logic [DW-1:0] fifo_dat_q [OFIFO_DEPTH];
  logic [OFIFO_DEPTH-1:0] fifo_lst_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] occ_q;
  logic [CW-1:0] cred;
  logic          wr_acc, rd_acc, push, pop;

  // Valid/ready: a transfer happens on a rising edge where vld & rdy are both
  // high; a requester holds vld and its payload until that edge.
  assign wr_acc    = din_vld_i & din_rdy_o;
  assign rd_acc    = add_vld_i & add_rdy_o;
  assign push      = infl_q;
  assign pop       = dat_vld_o & dat_rdy_i;
  assign din_rdy_o = open_i & ~acc_p_q;
  // Credit counts entries already committed to the FIFO after this edge.
  assign cred      = CW'(occ_q) + CW'(infl_q) - CW'(pop);
  assign add_rdy_o = open_i & ~din_vld_i & (cred < CRED_MAX);

  assign acc_dat  = DW'(sat_add(int'($signed(ram_dout_q)), int'($signed(din_dat_q)), DW));
  assign push_dat = fwd_q ? fwd_dat_q : ram_dout_q;
  assign ram_ra   = din_vld_i ? din_add_i : add_add_i;

  // Clear beats a pending accumulate write-back if they ever coincide.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = din_add_i;
    ram_wd = din_dat_i;
    if (clr_we_i) begin
      ram_we = 1'b1;
      ram_wa = clr_add_i;
      ram_wd = '0;
    end else if (acc_p_q) begin
      ram_we = 1'b1;
      ram_wa = din_add_q;
      ram_wd = acc_dat;
    end else if (wr_acc && !din_acc_i) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    ram_dout_q <= mem[ram_ra];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p_q    <= 1'b0;
      din_add_q  <= '0;
      din_dat_q  <= '0;
      infl_q     <= 1'b0;
      lst_q      <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_dat_q  <= '0;
      fifo_lst_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      for (int i = 0; i < OFIFO_DEPTH; i++) fifo_dat_q[i] <= '0;
    end else begin
      acc_p_q <= wr_acc & din_acc_i;
      if (wr_acc) begin
        din_add_q <= din_add_i;
        din_dat_q <= din_dat_i;
      end
      infl_q <= rd_acc;
      if (rd_acc) lst_q <= add_lst_i;
      // The RAM read races the write-back in the acc_p cycle, so capture the sum.
      fwd_q     <= rd_acc & acc_p_q & (add_add_i == din_add_q);
      fwd_dat_q <= acc_dat;
      if (push) begin
        fifo_dat_q[wr_ptr_q] <= push_dat;
        fifo_lst_q[wr_ptr_q] <= lst_q;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      if (push && !pop) occ_q <= occ_q + OW'(1);
      else if (!push && pop) occ_q <= occ_q - OW'(1);
    end
  end

  assign dat_vld_o = (occ_q != '0);
  assign dat_dat_o = fifo_dat_q[rd_ptr_q];
  assign dat_lst_o = fifo_lst_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ_q == OCC_FULL));

endmodule

// File: rtl/eeg_oram_bank.sv
// EEG output RAM bank: CH channels plus the global zero-fill clear FSM.
// clr_busy mirrors the FSM state (high exactly while in ST_CLR).
module eeg_oram_bank import eeg_oram_pkg::*; #(
  parameter  int CH          = CH_DEF,
  parameter  int DEPTH       = DEPTH_DEF,
  parameter  int DW          = DW_DEF,
  parameter  int OFIFO_DEPTH = OFIFO_DEPTH_DEF,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic [CH-1:0]    din_vld,
  output logic [CH-1:0]    din_rdy,
  input  logic [CH-1:0]    din_acc,
  input  logic [CH*AW-1:0] din_add,
  input  logic [CH*DW-1:0] din_dat,
  input  logic [CH-1:0]    add_vld,
  input  logic [CH-1:0]    add_lst,
  output logic [CH-1:0]    add_rdy,
  input  logic [CH*AW-1:0] add_add,
  output logic [CH-1:0]    dat_vld,
  output logic [CH-1:0]    dat_lst,
  input  logic [CH-1:0]    dat_rdy,
  output logic [CH*DW-1:0] dat_dat
);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          up_q, open;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (clr_req) begin
        state_d = ST_CLR;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == CNT_LAST) state_d = ST_IDLE;
    end
  end

  // up_q keeps both ready outputs low until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      up_q    <= 1'b1;
    end
  end

  assign clr_busy = (state_q == ST_CLR);
  assign open     = up_q & (state_q == ST_IDLE);

  for (genvar i = 0; i < CH; i++) begin : g_chn
    eeg_oram_chn #(
      .DEPTH(DEPTH), .DW(DW), .OFIFO_DEPTH(OFIFO_DEPTH), .AW(AW)
    ) u_chn (
      .clk       (clk),
      .rst       (rst),
      .open_i    (open),
      .clr_we_i  (clr_busy),
      .clr_add_i (cnt_q),
      .din_vld_i (din_vld[i]),
      .din_rdy_o (din_rdy[i]),
      .din_acc_i (din_acc[i]),
      .din_add_i (din_add[i*AW +: AW]),
      .din_dat_i (din_dat[i*DW +: DW]),
      .add_vld_i (add_vld[i]),
      .add_lst_i (add_lst[i]),
      .add_rdy_o (add_rdy[i]),
      .add_add_i (add_add[i*AW +: AW]),
      .dat_vld_o (dat_vld[i]),
      .dat_lst_o (dat_lst[i]),
      .dat_rdy_i (dat_rdy[i]),
      .dat_dat_o (dat_dat[i*DW +: DW])
    );
  end

endmodule
